ram64_arbiter: RTL and testbench
================================

# ram64_arbiter

Two-client round-robin arbiter that shares a single `ram64` (64 x 16-bit, combinational read, write on `clk` rising edge when `load`) between requesters A and B. It sits between the two clients and the memory, serializes their accesses one per cycle, returns registered read data, and supports a bounded lock for read-modify-write sequences.

## Interface
Parameters:
- `MAX_LOCK`, 4: max consecutive grants one client may hold via `lock` while the other is requesting; range 1..15.

Ports:
- `clk`  in  1  system clock, all state changes on rising edge
- `reset`  in  1  synchronous, active-high reset
- `a_req`, `b_req`  in  1  access request, held until `x_gnt` seen
- `a_we`, `b_we`  in  1  1 = write, 0 = read
- `a_lock`, `b_lock`  in  1  request to keep the grant next cycle
- `a_addr`, `b_addr`  in  6  word address
- `a_wdata`, `b_wdata`  in  16  write data
- `a_gnt`, `b_gnt`  out  1  access performed this cycle
- `a_rvalid`, `b_rvalid`  out  1  one-cycle pulse, read data valid
- `a_rdata`, `b_rdata`  out  16  registered read data
- `mem_addr`  out  6  to `ram64` address
- `mem_in`  out  16  to `ram64` in
- `mem_load`  out  1  to `ram64` load
- `mem_out`  in  16  from `ram64` out

## Operation
- States (registered owner): IDLE, SERVE_A, SERVE_B. `a_gnt` = (state == SERVE_A), `b_gnt` = (state == SERVE_B).
- Each rising edge the next owner is chosen from `a_req`/`b_req`:
  - Lock continuation: if current owner X has `x_req & x_lock` and `lock_cnt < MAX_LOCK`, X keeps the grant and `lock_cnt` increments. If the other client is not requesting, lock continuation is unlimited and `lock_cnt` saturates at `MAX_LOCK`.
  - Otherwise round-robin: if only one client requests, it wins. If both request, the client holding the priority pointer wins. The pointer moves to the other client after every grant issued.
  - No request leads to IDLE.
- `lock_cnt` clears on any owner change or on IDLE.
- Granted cycle: `mem_addr`/`mem_in` come from the owner's inputs, and `mem_load = owner_we & ~reset`. In IDLE, `mem_addr = 0`, `mem_in = 0`, `mem_load = 0`.
- Reads: at the end of the granted cycle, `mem_out` is captured into the owner's `x_rdata`, and `x_rvalid` pulses the next cycle. `x_rdata` holds its value until the next read by that client.
- A client that keeps `req` high after its `gnt` cycle issues a new request. The arbiter does not deduplicate requests.
- Clients must keep `addr`/`we`/`wdata` stable while `req` is high and `gnt` is low.

## Timing
- Reset values: state IDLE, priority pointer A, `lock_cnt` 0. All `gnt`, `rvalid` and `mem_load` are 0. `rdata` is 0, `mem_addr` 0, `mem_in` 0.
- Latency: `req` sampled at edge 0, `gnt` high in cycle 1, write committed at edge 1, and for reads `rvalid`/`rdata` are valid in cycle 2.
- Throughput: one access per cycle. Both clients requesting continuously without lock produces an A,B,A,B alternation.
- Simultaneous request with the pointer at B: B is granted first, then A.
- Reset asserted during a granted write cycle: `mem_load` is forced to 0, so no write occurs. No `rvalid` is produced for an interrupted read.
- Dropping `req` during the `gnt` cycle has no effect; the access completes.
- Lock with `MAX_LOCK` reached while the other client is requesting: the grant is forced to the other client, and the pointer then returns priority to the locker.

## Structure
- Shared package/header `ram64_defs`: `RAM_DW = 16`, `RAM_AW = 6`, and the state encodings IDLE/SERVE_A/SERVE_B.
- Sub-module `ram64_rr_pick`: a combinational 2-way picker with inputs `req[1:0]`, `ptr`, and lock-continuation terms, and outputs the next owner.
- The arbiter holds the state, pointer, `lock_cnt`, the memory mux, and the rdata/rvalid registers.
- `ram64` is instantiated beside the arbiter at the top level, not inside it.

## Test plan
- Reset, then A writes 16'd123 to addr 5, then A reads addr 5 → `a_gnt` in cycle 1, `mem_load` = 1 that cycle, `a_rvalid` two cycles after the read request with `a_rdata` = 123.
- Both clients request continuously from reset (A writes addr 1..4, B reads addr 1..4) → grant order A,B,A,B, and B reads return the values A just wrote.
- Set the pointer to B (single B access first), then A and B request together → B is granted before A.
- A holds `lock` with B requesting and `MAX_LOCK` = 4 → A is granted 5 consecutive cycles (1 plus 4 continuations), then B is granted.
- Assert reset in A's write `gnt` cycle (addr 9, data 16'hBEEF, memory previously 0) → `mem_load` = 0 and a later read of addr 9 returns 0. All outputs are at their reset values the next cycle.
- B requests a read, then drops `req` in its `gnt` cycle → exactly one `b_rvalid` pulse and the state returns to IDLE.

Source files
------------

// File: rtl/ram64_arbiter_pkg.sv
// Shared widths and owner-state encoding for the two-client ram64 arbiter.
package ram64_defs;

    localparam int RAM_DW = 16;
    localparam int RAM_AW = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } state_t;

    // Which client wins when both request and no lock is continuing.
    typedef enum logic {
        PTR_A = 1'b0,
        PTR_B = 1'b1
    } ptr_t;

endpackage

// File: rtl/ram64_arbiter_if.sv
// One client port of the arbiter: request side driven by the client, grant/read side by the arbiter.
interface ram64_arbiter_if;
    import ram64_defs::*;

    // Handshake: the client raises req with stable we/addr/wdata and holds it until gnt.
    // gnt high marks the cycle the access is performed on the memory; lock asks to keep
    // the grant next cycle; rvalid pulses for one cycle after a read's gnt with rdata valid.
    logic              req;
    logic              we;
    logic              lock;
    logic [RAM_AW-1:0] addr;
    logic [RAM_DW-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [RAM_DW-1:0] rdata;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/ram64_arbiter_rr_pick.sv
// Combinational next-owner picker: lock continuation first, then two-way round robin.
module ram64_rr_pick
    import ram64_defs::*;
(
    input  logic [1:0] req,
    input  ptr_t       ptr,
    input  logic       keep_a,
    input  logic       keep_b,
    output state_t     next_owner,
    output logic       next_locked
);

    always_comb begin
        next_owner  = IDLE;
        next_locked = 1'b0;
        if (keep_a) begin
            next_owner  = SERVE_A;
            next_locked = 1'b1;
        end else if (keep_b) begin
            next_owner  = SERVE_B;
            next_locked = 1'b1;
        end else if (req[0] && req[1]) begin
            next_owner = (ptr == PTR_B) ? SERVE_B : SERVE_A;
        end else if (req[0]) begin
            next_owner = SERVE_A;
        end else if (req[1]) begin
            next_owner = SERVE_B;
        end
    end

endmodule

// File: rtl/ram64_arbiter.sv
// Round-robin arbiter sharing one ram64 between clients A and B, with bounded lock
// for read-modify-write and registered read data per client.
module ram64_arbiter
    import ram64_defs::*;
#(
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic              clk,
    input  logic              reset,
    ram64_arbiter_if.slave    a,
    ram64_arbiter_if.slave    b,
    output logic [RAM_AW-1:0] mem_addr,
    output logic [RAM_DW-1:0] mem_in,
    output logic              mem_load,
    input  logic [RAM_DW-1:0] mem_out,
    output state_t            dbg_state
);

    localparam logic [3:0] LOCK_MAX = 4'(MAX_LOCK);

    state_t            state;
    state_t            next_state;
    ptr_t              ptr;
    logic [3:0]        lock_cnt;
    logic              keep_a;
    logic              keep_b;
    logic              next_locked;
    logic              a_rvalid_q;
    logic              b_rvalid_q;
    logic [RAM_DW-1:0] a_rdata_q;
    logic [RAM_DW-1:0] b_rdata_q;

    // The lock budget only applies while the other client is actually waiting.
    always_comb begin
        keep_a = (state == SERVE_A) && a.req && a.lock && ((lock_cnt < LOCK_MAX) || !b.req);
        keep_b = (state == SERVE_B) && b.req && b.lock && ((lock_cnt < LOCK_MAX) || !a.req);
    end

    ram64_rr_pick u_pick (
        .req         ({b.req, a.req}),
        .ptr         (ptr),
        .keep_a      (keep_a),
        .keep_b      (keep_b),
        .next_owner  (next_state),
        .next_locked (next_locked)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= PTR_A;
            lock_cnt <= '0;
        end else begin
            state <= next_state;
            // Every grant hands priority to the other client.
            if (next_state == SERVE_A) begin
                ptr <= PTR_B;
            end else if (next_state == SERVE_B) begin
                ptr <= PTR_A;
            end
            if (!next_locked) begin
                lock_cnt <= '0;
            end else if (lock_cnt != LOCK_MAX) begin
                lock_cnt <= lock_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        mem_addr = '0;
        mem_in   = '0;
        mem_load = 1'b0;
        case (state)
            SERVE_A: begin
                mem_addr = a.addr;
                mem_in   = a.wdata;
                mem_load = a.we & ~reset;
            end
            SERVE_B: begin
                mem_addr = b.addr;
                mem_in   = b.wdata;
                mem_load = b.we & ~reset;
            end
            default: ;
        endcase
    end

    // Read data is captured at the end of the granted cycle; reset drops an interrupted read.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            a_rvalid_q <= (state == SERVE_A) && !a.we;
            b_rvalid_q <= (state == SERVE_B) && !b.we;
            if ((state == SERVE_A) && !a.we) begin
                a_rdata_q <= mem_out;
            end
            if ((state == SERVE_B) && !b.we) begin
                b_rdata_q <= mem_out;
            end
        end
    end

    assign a.gnt     = (state == SERVE_A);
    assign b.gnt     = (state == SERVE_B);
    assign a.rvalid  = a_rvalid_q;
    assign b.rvalid  = b_rvalid_q;
    assign a.rdata   = a_rdata_q;
    assign b.rdata   = b_rdata_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_ram64_arbiter.sv
// Bench for ram64_arbiter: directed scenarios then random traffic, checked every cycle
// against a transaction-level model of owner, priority, lock streak and memory contents.
module tb_ram64_arbiter;
    import ram64_defs::*;

    localparam int MAX_LOCK = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  mem_addr;
    logic [15:0] mem_in;
    logic        mem_load;
    logic [15:0] mem_out;
    state_t      dbg_state;

    ram64_arbiter_if a_if ();
    ram64_arbiter_if b_if ();

    // client drive values, index 0 = A, 1 = B
    logic        c_req  [2];
    logic        c_we   [2];
    logic        c_lock [2];
    logic [5:0]  c_addr [2];
    logic [15:0] c_wd   [2];

    assign a_if.req   = c_req[0];
    assign a_if.we    = c_we[0];
    assign a_if.lock  = c_lock[0];
    assign a_if.addr  = c_addr[0];
    assign a_if.wdata = c_wd[0];
    assign b_if.req   = c_req[1];
    assign b_if.we    = c_we[1];
    assign b_if.lock  = c_lock[1];
    assign b_if.addr  = c_addr[1];
    assign b_if.wdata = c_wd[1];

    ram64_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
        .clk       (clk),
        .reset     (rst),
        .a         (a_if),
        .b         (b_if),
        .mem_addr  (mem_addr),
        .mem_in    (mem_in),
        .mem_load  (mem_load),
        .mem_out   (mem_out),
        .dbg_state (dbg_state)
    );

    // the shared ram64 beside the arbiter
    logic [15:0] ram [64] = '{default: 16'h0};
    always @(posedge clk) if (mem_load) ram[mem_addr] <= mem_in;
    assign mem_out = ram[mem_addr];

    always #5 clk = ~clk;

    // reference model: owner -1 none / 0 A / 1 B, prio = client that wins a tie
    int          m_owner;
    int          m_prio;
    int          m_streak;
    logic [15:0] mm [64] = '{default: 16'h0};
    logic        e_rv [2];
    logic [15:0] e_rd [2];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic gnt_of(input int c);
        return (c == 0) ? a_if.gnt : b_if.gnt;
    endfunction

    task automatic model_edge();
        int nxt;
        bit locked;
        if (rst) begin
            m_owner = -1; m_prio = 0; m_streak = 0;
            e_rv[0] = 0; e_rv[1] = 0; e_rd[0] = '0; e_rd[1] = '0;
            return;
        end
        e_rv[0] = 0;
        e_rv[1] = 0;
        if (m_owner >= 0) begin
            if (c_we[m_owner]) mm[c_addr[m_owner]] = c_wd[m_owner];
            else begin
                e_rv[m_owner] = 1;
                e_rd[m_owner] = mm[c_addr[m_owner]];
            end
        end
        nxt = -1;
        locked = 0;
        if (m_owner >= 0 && c_req[m_owner] && c_lock[m_owner] &&
            (m_streak < MAX_LOCK || !c_req[1 - m_owner])) begin
            nxt = m_owner;
            locked = 1;
        end else if (c_req[0] && c_req[1]) nxt = m_prio;
        else if (c_req[0]) nxt = 0;
        else if (c_req[1]) nxt = 1;
        m_streak = locked ? ((m_streak < MAX_LOCK) ? m_streak + 1 : MAX_LOCK) : 0;
        if (nxt >= 0) m_prio = 1 - nxt;
        m_owner = nxt;
    endtask

    task automatic check_outputs();
        logic [5:0]  ea;
        logic [15:0] ei;
        logic        el;
        ea = '0; ei = '0; el = 1'b0;
        if (m_owner >= 0) begin
            ea = c_addr[m_owner];
            ei = c_wd[m_owner];
            el = c_we[m_owner] & ~rst;
        end
        check("a_gnt", a_if.gnt, m_owner == 0);
        check("b_gnt", b_if.gnt, m_owner == 1);
        check("mem_addr", mem_addr, ea);
        check("mem_in", mem_in, ei);
        check("mem_load", mem_load, el);
        check("a_rvalid", a_if.rvalid, e_rv[0]);
        check("b_rvalid", b_if.rvalid, e_rv[1]);
        check("a_rdata", a_if.rdata, e_rd[0]);
        check("b_rdata", b_if.rdata, e_rd[1]);
    endtask

    // inputs change at +1 after an edge; outputs checked at +3; model steps on the edge
    task automatic tick();
        #2;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_client(input int c, input logic req, input logic we, input logic lock,
                              input logic [5:0] addr, input logic [15:0] wd);
        c_req[c] = req; c_we[c] = we; c_lock[c] = lock; c_addr[c] = addr; c_wd[c] = wd;
    endtask

    task automatic access(input int c, input logic we, input logic [5:0] addr, input logic [15:0] wd);
        bit got;
        got = 0;
        set_client(c, 1'b1, we, 1'b0, addr, wd);
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (gnt_of(c)) got = 1;
        end
        check("access_wait", got, 1'b1);
        c_req[c] = 1'b0;
        tick();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt;
        rst = 1'b1;
        set_client(0, 0, 0, 0, '0, '0);
        set_client(1, 0, 0, 0, '0, '0);
        @(posedge clk); model_edge(); #1;
        @(posedge clk); model_edge(); #1;
        check("rst_state", dbg_state, IDLE);
        check("rst_gnt", {a_if.gnt, b_if.gnt}, 2'b00);
        check("rst_rvalid", {a_if.rvalid, b_if.rvalid}, 2'b00);
        check("rst_mem", {mem_addr, mem_in, mem_load}, 23'd0);
        rst = 1'b0;

        // write 123 to addr 5, then read it back
        set_client(0, 1, 1, 0, 6'd5, 16'd123);
        tick();
        check("wr_gnt_lat", a_if.gnt, 1'b1);
        check("wr_mem_load", mem_load, 1'b1);
        c_req[0] = 1'b0;
        tick();
        set_client(0, 1, 0, 0, 6'd5, 16'd0);
        tick();
        check("rd_gnt_lat", a_if.gnt, 1'b1);
        c_req[0] = 1'b0;
        tick();
        check("rd_rvalid", a_if.rvalid, 1'b1);
        check("rd_rdata_123", a_if.rdata, 16'd123);

        // continuous requests from reset: A writes 1..4, B reads 1..4
        pulse_reset();
        set_client(0, 1, 1, 0, 6'd1, 16'h1001);
        set_client(1, 1, 0, 0, 6'd1, 16'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rr_order_a", a_if.gnt, (i % 2) == 0);
            check("rr_order_b", b_if.gnt, (i % 2) == 1);
            if (i % 2 == 1) begin
                c_addr[0] = 6'(1 + (i + 1) / 2);
                c_wd[0]   = 16'h1000 + 16'(1 + (i + 1) / 2);
            end else if (i >= 2) begin
                check("rr_b_rdata", b_if.rdata, 16'h1000 + 16'(i / 2));
                c_addr[1] = 6'(1 + i / 2);
            end
        end
        c_req[0] = 1'b0;
        c_req[1] = 1'b0;
        tick();
        tick();

        // a single A grant hands priority to B, so a tie goes B then A
        access(0, 1'b0, 6'd2, 16'd0);
        set_client(0, 1, 0, 0, 6'd3, 16'd0);
        set_client(1, 1, 0, 0, 6'd4, 16'd0);
        tick();
        check("tie_b_first", b_if.gnt, 1'b1);
        c_req[1] = 1'b0;
        tick();
        check("tie_a_second", a_if.gnt, 1'b1);
        c_req[0] = 1'b0;
        tick();

        // A locks with B waiting: 5 A grants then B
        pulse_reset();
        set_client(0, 1, 0, 1, 6'h10, 16'd0);
        set_client(1, 1, 0, 0, 6'h11, 16'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("lock_a", a_if.gnt, i < 5);
            check("lock_b", b_if.gnt, i == 5);
        end
        set_client(0, 0, 0, 0, 6'h10, 16'd0);
        c_req[1] = 1'b0;
        tick();
        tick();

        // reset during A's write grant cancels the write
        set_client(0, 1, 1, 0, 6'd9, 16'hBEEF);
        tick();
        check("rstwr_gnt", a_if.gnt, 1'b1);
        rst = 1'b1;
        #1;
        check("rstwr_mem_load", mem_load, 1'b0);
        c_req[0] = 1'b0;
        tick();
        check("rstwr_state", dbg_state, IDLE);
        check("rstwr_outs", {a_if.gnt, b_if.gnt, a_if.rvalid, b_if.rvalid, mem_load}, 5'd0);
        check("rstwr_rdata", {a_if.rdata, b_if.rdata}, 32'd0);
        rst = 1'b0;
        access(0, 1'b0, 6'd9, 16'd0);
        check("rstwr_rd_valid", a_if.rvalid, 1'b1);
        check("rstwr_rd_data", a_if.rdata, 16'd0);

        // B drops req in its grant cycle: one rvalid, back to IDLE
        access(1, 1'b0, 6'd1, 16'd0);
        cnt = int'(b_if.rvalid);
        repeat (3) begin
            tick();
            cnt += int'(b_if.rvalid);
        end
        check("drop_one_rvalid", cnt, 1);
        check("drop_idle", dbg_state, IDLE);

        // random traffic on a small address window
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            for (int c = 0; c < 2; c++) begin
                if (gnt_of(c)) begin
                    c_req[c]  = 1'($urandom_range(0, 1));
                    c_lock[c] = 1'($urandom_range(0, 1));
                end else if (!c_req[c] && $urandom_range(0, 2) == 0) begin
                    set_client(c, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                               6'($urandom_range(0, 7)), 16'($urandom));
                end
            end
            tick();
        end
        rst = 1'b0;
        c_req[0] = 1'b0;
        c_req[1] = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
